// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester round-robin arbiter in front of one shared memory port.
//   It runs one transaction at a time. It steers the external addr/wdata
//   muxes (SEL), raises MEM_REQ and waits for MEM_RDY or a timeout. It then
//   returns a one-cycle ACK with registered read data to the winner.
//   Requester 0 = fetch, requester 1 = load/store.
// Ports
//   CLK, RST_N        clock, async active-low reset
//   REQ_x, WE_x       request (held until ACK) and its write enable
//   ACK_x, ERR        one-cycle completion pulse, ERR marks a timeout
//   RDAT              read data captured at completion (held)
//   SEL               external mux select, 0 = requester 0
//   MEM_REQ/MEM_WE    shared-port request and write enable
//   MEM_RDY/MEM_RDAT  shared-port completion and read data
module mem_port_arbiter #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          REQ_0,
  input  logic          REQ_1,
  input  logic          WE_0,
  input  logic          WE_1,
  output logic          ACK_0,
  output logic          ACK_1,
  output logic          ERR,
  output logic [DW-1:0] RDAT,
  output logic          SEL,
  output logic          MEM_REQ,
  output logic          MEM_WE,
  input  logic          MEM_RDY,
  input  logic [DW-1:0] MEM_RDAT
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            last, last_n;
  logic            sel_n, mem_req_n, mem_we_n, ack0_n, ack1_n, err_n;
  logic [DW-1:0]   rdat_n;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= 1'b1;   // requester 0 wins the first contention
      SEL     <= 1'b0;
      MEM_REQ <= 1'b0;
      MEM_WE  <= 1'b0;
      ACK_0   <= 1'b0;
      ACK_1   <= 1'b0;
      ERR     <= 1'b0;
      RDAT    <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      last    <= last_n;
      SEL     <= sel_n;
      MEM_REQ <= mem_req_n;
      MEM_WE  <= mem_we_n;
      ACK_0   <= ack0_n;
      ACK_1   <= ack1_n;
      ERR     <= err_n;
      RDAT    <= rdat_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    last_n    = last;
    sel_n     = SEL;     // SEL only moves on IDLE->GRANT
    mem_req_n = MEM_REQ;
    mem_we_n  = MEM_WE;
    ack0_n    = ACK_0;
    ack1_n    = ACK_1;
    err_n     = ERR;
    rdat_n    = RDAT;
    case (state)
      IDLE: begin
        if (REQ_0 || REQ_1) begin
          // Contention goes to whoever did not win last; a lone requester wins.
          sel_n     = (REQ_0 && REQ_1) ? ~last : REQ_1;
          mem_req_n = 1'b1;
          mem_we_n  = sel_n ? WE_1 : WE_0;
          cnt_n     = '0;
          state_n   = GRANT;
        end
      end
      GRANT: begin
        // cnt counts completed wait cycles, so the limit TIMEOUT-1 keeps
        // MEM_REQ up for exactly TIMEOUT cycles. MEM_RDY wins a tie.
        if (MEM_RDY || cnt == CW'(TIMEOUT - 1)) begin
          rdat_n    = MEM_RDY ? MEM_RDAT : '0;
          err_n     = ~MEM_RDY;
          ack0_n    = ~SEL;
          ack1_n    = SEL;
          mem_req_n = 1'b0;
          mem_we_n  = 1'b0;
          last_n    = SEL;
          state_n   = RESP;
        end else if (cnt != '1) begin
          cnt_n = cnt + CW'(1);
        end
      end
      RESP: begin
        ack0_n  = 1'b0;
        ack1_n  = 1'b0;
        err_n   = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester round-robin arbiter that owns a single shared 32-bit memory port. It sequences one transaction at a time: it drives the `SEL` line of the 2:1 address and write-data muxes in front of the port, issues the port request, and waits for ready or a timeout. It then returns a one-cycle acknowledge with registered read data to the granted requester. It sits between the fetch path (requester 0), the load/store path (requester 1) and the data memory.

## Interface
Parameters:
- `DW`, 32, data/read-data width
- `TIMEOUT`, 15, max cycles in GRANT without `MEM_RDY` before error completion (1..255)

Ports (one clock; reset is asynchronous and active-low):
- `CLK`  in  1  system clock, rising edge
- `RST_N`  in  1  asynchronous active-low reset
- `REQ_0`, `REQ_1`  in  1  transaction request; held high until ACK
- `WE_0`, `WE_1`  in  1  write enable accompanying request; stable while REQ high
- `ACK_0`, `ACK_1`  out  1  one-cycle completion pulse
- `ERR`  out  1  high with ACK when completion was by timeout
- `RDAT`  out  DW  read data captured at completion; holds until next completion
- `SEL`  out  1  select for external address/write-data muxes (0 = requester 0)
- `MEM_REQ`  out  1  shared-port request
- `MEM_WE`  out  1  shared-port write enable
- `MEM_RDY`  in  1  port completion, valid only while `MEM_REQ` high
- `MEM_RDAT`  in  DW  port read data, valid with `MEM_RDY`

## Operation
- FSM states: IDLE, GRANT, RESP. All outputs registered.
- IDLE: if any REQ high, go to GRANT. Winner: the single requester, or, if both, the one not in `LAST`. Set `SEL` = winner, `MEM_REQ`=1, `MEM_WE`=WE of winner, clear timeout counter.
- GRANT: if `MEM_RDY`=1, capture `MEM_RDAT` into `RDAT`, drop `MEM_REQ`/`MEM_WE`, set ACK of granted requester, `ERR`=0, `LAST`=`SEL`, go to RESP.
- GRANT without `MEM_RDY`: increment counter. When counter reaches `TIMEOUT`-1 and `MEM_RDY`=0, complete as above with `RDAT`=0 and `ERR`=1.
- RESP: clear ACK and `ERR`, go to IDLE unconditionally. The requester must drop REQ at the edge ending RESP.
- `SEL` changes only on the IDLE→GRANT transition. It holds its value in RESP and IDLE so the mux output never switches mid-transaction.
- Writes: `RDAT` is still updated from `MEM_RDAT` at completion. Requesters ignore it.
- REQ falling during GRANT is a protocol violation. The arbiter still completes the transaction and pulses ACK.
- Counter width: `$clog2(TIMEOUT+1)`. It saturates and does not wrap.

## Timing
- Reset (async, any state): state=IDLE, `SEL`=0, `MEM_REQ`=0, `MEM_WE`=0, `ACK_0`=`ACK_1`=0, `ERR`=0, `RDAT`=0, `LAST`=1 (requester 0 wins the first contention), counter=0.
- Reset mid-GRANT: `MEM_REQ` drops immediately and no ACK is issued. The requester must re-request.
- REQ high in cycle n (IDLE) → `MEM_REQ`, `SEL` valid in n+1.
- `MEM_RDY` in cycle m → ACK/`RDAT` valid in m+1 → IDLE in m+2.
- Minimum REQ→ACK is 2 cycles. Maximum throughput is one transaction per 3 cycles.
- Timeout: `MEM_REQ` high for exactly `TIMEOUT` cycles, then ACK+`ERR`.
- `MEM_RDY` in the same cycle the counter hits its limit: normal completion, `ERR`=0.
- Both REQ high continuously: grants alternate 0,1,0,1, with each requester re-requesting after its ACK.
- `MEM_RDY` while not in GRANT is ignored.

## Test plan
- Reset, `REQ_0`=1, `WE_0`=0, `MEM_RDY` on 3rd GRANT cycle with `MEM_RDAT`=32'hDEADBEEF → `SEL`=0, `MEM_REQ` high 3 cycles, `ACK_0` one cycle, `RDAT`=32'hDEADBEEF, `ERR`=0.
- Both REQ held high from reset, `MEM_RDY` immediate → grant order 0,1,0,1. ACKs spaced 3 cycles. `SEL` toggles only on IDLE→GRANT.
- `REQ_1`=1, `WE_1`=1, `MEM_RDY` never asserted, `TIMEOUT`=15 → `MEM_REQ`/`MEM_WE` high exactly 15 cycles, then `ACK_1`=1, `ERR`=1, `RDAT`=0.
- `MEM_RDY` asserted on the 15th GRANT cycle with `MEM_RDAT`=32'h1 → `ERR`=0, `RDAT`=32'h1.
- `RST_N` pulled low mid-GRANT (asynchronously, between edges) → `MEM_REQ`=0, `SEL`=0, no ACK. After release, pending `REQ_1` is granted in 1 cycle.
- Only `REQ_1` after a requester-1 transaction (`LAST`=1) → granted immediately. Round-robin never blocks a lone requester.
